regfile_wb_queue: RTL

//  Write-side front end for the 32x32 register file: buffers writeback requests from the

---
 rtl/regfile_wb_queue_if.sv | 31 +++
 rtl/regfile_wb_queue.sv | 97 +++++++++
 2 files changed

// File: rtl/regfile_wb_queue_if.sv
// Writeback request, regfile write port and forwarding lookup signals of the writeback queue.
// The master side is the pipeline/regfile; the slave side is the queue itself.
interface regfile_wb_queue_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_reg;
    logic [31:0] in_data;
    logic        wb_stall;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic        fwd_hit1;
    logic [31:0] fwd_data1;
    logic        fwd_hit2;
    logic [31:0] fwd_data2;
    logic        empty;

    modport master (
        output in_valid, in_reg, in_data, wb_stall, ReadRegister1, ReadRegister2,
        input  in_ready, RegWrite, WriteRegister, WriteData,
        input  fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, empty
    );

    modport slave (
        input  in_valid, in_reg, in_data, wb_stall, ReadRegister1, ReadRegister2,
        output in_ready, RegWrite, WriteRegister, WriteData,
        output fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, empty
    );
endinterface

// File: rtl/regfile_wb_queue.sv
// Writeback FIFO in front of the regfile write port: one drain per cycle, registered
// write outputs, and youngest-first forwarding lookup for both decode read ports.
module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic            clk,
    input  logic            reset,
    regfile_wb_queue_if.slave bus
);

    logic [4:0]    entryReg  [DEPTH];
    logic [31:0]   entryData [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [AW:0]   count;

    logic          regWriteQ;
    logic [4:0]    writeRegQ;
    logic [31:0]   writeDataQ;

    logic          full;
    logic          doPush;
    logic          doStore;
    logic          doPop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign doPush  = bus.in_valid && !full;
    // Writes to r0 complete the handshake but never occupy a slot.
    assign doStore = doPush && (bus.in_reg != 5'd0);
    assign doPop   = (count != '0) && !bus.wb_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            count      <= '0;
            regWriteQ  <= 1'b0;
            writeRegQ  <= '0;
            writeDataQ <= '0;
        end else begin
            if (doStore) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (doPop) begin
                rdPtr      <= rdPtr + AW'(1);
                regWriteQ  <= 1'b1;
                writeRegQ  <= entryReg[rdPtr];
                writeDataQ <= entryData[rdPtr];
            end else begin
                regWriteQ  <= 1'b0;
            end
            case ({doStore, doPop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Slot contents need no reset: occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (doStore) begin
            entryReg[wrPtr]  <= bus.in_reg;
            entryData[wrPtr] <= bus.in_data;
        end
    end

    // Walk from the output register to the youngest entry so later matches win.
    function automatic logic [32:0] lookup(input logic [4:0] addr);
        logic [32:0]   res;
        logic [AW-1:0] idx;
        res = '0;
        if (addr != 5'd0) begin
            if (regWriteQ && (writeRegQ == addr)) begin
                res = {1'b1, writeDataQ};
            end
            for (int k = 0; k < DEPTH; k++) begin
                idx = rdPtr + AW'(k);
                if (((AW+1)'(k) < count) && (entryReg[idx] == addr)) begin
                    res = {1'b1, entryData[idx]};
                end
            end
        end
        return res;
    endfunction

    assign {bus.fwd_hit1, bus.fwd_data1} = lookup(bus.ReadRegister1);
    assign {bus.fwd_hit2, bus.fwd_data2} = lookup(bus.ReadRegister2);

    assign bus.in_ready      = !full;
    assign bus.RegWrite      = regWriteQ;
    assign bus.WriteRegister = writeRegQ;
    assign bus.WriteData     = writeDataQ;
    assign bus.empty         = (count == '0) && !regWriteQ;

endmodule
